// File: rtl/clk_divider.sv
// clk_divider: integer clock divider producing clk_out = f(clk)/N at 50% duty
// for both even and odd N. clk_out is formed only from flop outputs (plus clk
// itself when N = 1), so it carries no combinational glitches.
//
// Parameters:
//   N        division ratio, 1..65535; anything else stops elaboration.
//
// Ports:
//   clk      input clock; every state change happens on one of its edges
//   rst      asynchronous active-low reset (0 = in reset, 1 = running);
//            deassertion is expected to be synchronised to clk upstream
//   clk_out  divided clock, period N*T(clk), high for N/2 input periods
//
// Edge numbering below counts clk rising edges after reset release, starting
// at 1. The counter sees value k-1 on rising edge k.
`timescale 1ns/1ps

module clk_divider #(
  parameter int N = 5
) (
  input  logic clk,
  input  logic rst,
  output logic clk_out
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (N < 1 || N > 65535) begin : g_bad_n
    $fatal(1, "clk_divider: N=%0d is outside the legal range 1..65535", N);
  end else if (N == 1) begin : g_div1
    // Pass clk through once a falling edge has been seen after release. The
    // flag only changes while clk is low, so the gate cannot cut a high phase
    // short and clk_out never shows a runt pulse.
    logic run_q;
    logic run_d;

    always_comb begin
      run_d = 1'b1;
    end

    always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
        run_q <= 1'b0;
      end else begin
        run_q <= run_d;
      end
    end

    assign clk_out = clk & run_q;

  end else if ((N % 2) == 0) begin : g_even
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(N / 2 - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             p_q;
    logic             p_d;

    always_comb begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      p_d   = p_q;
      // Toggle twice per output period; decisions use the pre-increment count.
      if (cnt_q == HALF_M1 || cnt_q == CNT_MAX) begin
        p_d = ~p_q;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        p_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        p_q   <= p_d;
      end
    end

    assign clk_out = p_q;

  end else begin : g_odd
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] RISE_CNT = CNT_W'((N - 1) / 2 - 1);
    localparam logic [CNT_W-1:0] FALL_CNT = CNT_W'(N - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             p_q;
    logic             p_d;
    logic             q_q;
    logic             q_d;

    always_comb begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      p_d   = p_q;
      if (cnt_q == RISE_CNT) begin
        p_d = 1'b1;
      end else if (cnt_q == FALL_CNT) begin
        p_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        p_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        p_q   <= p_d;
      end
    end

    // p delayed by half an input period; OR-ing it in stretches the high
    // phase from (N-1)/2 periods to N/2 periods, ending on a clk falling edge.
    always_comb begin
      q_d = p_q;
    end

    always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
        q_q <= 1'b0;
      end else begin
        q_q <= q_d;
      end
    end

    assign clk_out = p_q | q_q;
  end

endmodule

// File: tb/tb_clk_divider.sv
`timescale 1ns/1ps

module tb_clk_divider;

  logic clk;
  logic rst;
  logic co1, co2, co3, co4, co5, co7;

  int n_checks = 0;
  int n_errors = 0;

  // Edge-timing monitor state for the N=7 instance
  logic mon_en = 1'b0;
  logic have_rise = 1'b0;
  logic have_fall = 1'b0;
  time  t_rise = 0;
  time  t_fall = 0;
  int   n_rise7 = 0;

  clk_divider #(.N(1)) u_n1 (.clk(clk), .rst(rst), .clk_out(co1));
  clk_divider #(.N(2)) u_n2 (.clk(clk), .rst(rst), .clk_out(co2));
  clk_divider #(.N(3)) u_n3 (.clk(clk), .rst(rst), .clk_out(co3));
  clk_divider #(.N(4)) u_n4 (.clk(clk), .rst(rst), .clk_out(co4));
  clk_divider #(.N(5)) u_n5 (.clk(clk), .rst(rst), .clk_out(co5));
  clk_divider #(.N(7)) u_n7 (.clk(clk), .rst(rst), .clk_out(co7));

  // 20 ns period: rising edges at 5, 25, 45, ..., falling edges at 15, 35, ...
  initial begin
    clk = 1'b0;
    #5;
    forever begin
      clk = 1'b1;
      #10;
      clk = 1'b0;
      #10;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Half-cycle slot h after release: even h follows rising edge h/2+1, odd h
  // follows the falling edge after it. clk_out is high in slots
  // off .. off+N-1 of each 2N-slot period, where off = 2*(first rise edge - 1).
  function automatic logic exp_out(input int n, input int off, input int h);
    if (h < off) return 1'b0;
    return ((h - off) % (2 * n)) < n;
  endfunction

  task automatic check_all_zero(input string tag);
    check_val({tag, "_n1"}, 32'(co1), 0);
    check_val({tag, "_n2"}, 32'(co2), 0);
    check_val({tag, "_n3"}, 32'(co3), 0);
    check_val({tag, "_n4"}, 32'(co4), 0);
    check_val({tag, "_n5"}, 32'(co5), 0);
    check_val({tag, "_n7"}, 32'(co7), 0);
  endtask

  // First-rise edges: N=1 ->1, N=2 ->1, N=3 ->1, N=4 ->2, N=5 ->2, N=7 ->3
  task automatic run_slots(input int start, input int count);
    for (int i = 0; i < count; i++) begin
      int h;
      h = start + i;
      if ((h % 2) == 0) @(posedge clk);
      else              @(negedge clk);
      #5;
      check_val($sformatf("n1_h%0d", h), 32'(co1), 32'(exp_out(1, 0, h)));
      check_val($sformatf("n2_h%0d", h), 32'(co2), 32'(exp_out(2, 0, h)));
      check_val($sformatf("n3_h%0d", h), 32'(co3), 32'(exp_out(3, 0, h)));
      check_val($sformatf("n4_h%0d", h), 32'(co4), 32'(exp_out(4, 2, h)));
      check_val($sformatf("n5_h%0d", h), 32'(co5), 32'(exp_out(5, 2, h)));
      check_val($sformatf("n7_h%0d", h), 32'(co7), 32'(exp_out(7, 4, h)));
    end
  endtask

  always @(co7) begin
    if (mon_en) begin
      if (co7) begin
        n_rise7++;
        if (have_rise) check_val("n7_period", 32'($time - t_rise), 140);
        if (have_fall) check_val("n7_low", 32'($time - t_fall), 70);
        t_rise    = $time;
        have_rise = 1'b1;
      end else begin
        if (have_rise) check_val("n7_high", 32'($time - t_rise), 70);
        t_fall    = $time;
        have_fall = 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b0;
    #1;
    check_all_zero("rst_t1");
    #9;
    check_all_zero("rst_clkhi");
    #40;
    rst = 1'b1;                 // t=50, 5 ns before a falling edge
    #2;
    check_all_zero("rel_clkhi");
    #8;
    check_all_zero("rel_clklo");

    run_slots(0, 42);

    // Slot 42: N=5 output is high, clk is high; reset in mid cycle
    @(posedge clk);
    #3;
    check_val("pre_rst_n5", 32'(co5), 1);
    check_val("pre_rst_n1", 32'(co1), 1);
    rst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    repeat (3) begin
      @(posedge clk);
      #5;
      check_all_zero("hold_rst");
    end
    @(posedge clk);
    #5;
    rst = 1'b1;                 // same phase as the power-up release
    #2;
    check_all_zero("rel2_clkhi");
    @(negedge clk);
    #5;
    check_all_zero("rel2_clklo");

    run_slots(0, 20);

    mon_en = 1'b1;
    run_slots(20, 14014);
    mon_en = 1'b0;
    check_val("n7_rise_count", 32'(n_rise7), 1001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
